// File: rtl/uart_rx_core.sv
// ---------------------------------------------------------------------------
// UartRxCore (module uart_rx_core)
//
// Parametrised UART receiver. The serial line is brought into the clock
// domain through a two-flop synchroniser. The receiver then validates the
// start bit at mid-bit, shifts in DATAWIDTH data bits LSB first, and
// optionally checks a parity bit. Each frame is closed by one or two stop
// bits, and every completed frame produces a one-cycle o_wr pulse.
//
// Parameters:
//   CLKS_PER_BAUD  clock cycles per bit (4..65535)
//   DATAWIDTH      data bits per frame (5..8)
//   PARITY         0 = none, 1 = odd, 2 = even
//   STOP_BITS      1 or 2
//
// Ports:
//   clk            system clock, rising edge
//   i_reset        synchronous active-high reset
//   i_rx_data      asynchronous serial input, idle high
//   o_wr           one-cycle pulse, word and status valid
//   o_data         received word, LSB = first bit on the wire
//   o_parity_err   parity mismatch for the delivered word
//   o_frame_err    a stop bit was sampled low for the delivered word
//   o_break        break detected for the delivered word
//   o_busy         receiver is somewhere other than IDLE
//
// Optional feature macro: UART_RX_BREAK_DETECT_EN
//   When defined, an all-zero frame with a low stop bit (and a low parity
//   bit, if parity is used) is reported as a break. The receiver then parks
//   in BREAK until the line returns high. Without the macro, o_break is
//   tied low.
// ---------------------------------------------------------------------------
module uart_rx_core #(
   parameter int CLKS_PER_BAUD = 10416,
   parameter int DATAWIDTH     = 8,
   parameter int PARITY        = 0,
   parameter int STOP_BITS     = 1
) (
   input  logic                 clk,
   input  logic                 i_reset,
   input  logic                 i_rx_data,
   output logic                 o_wr,
   output logic [DATAWIDTH-1:0] o_data,
   output logic                 o_parity_err,
   output logic                 o_frame_err,
   output logic                 o_break,
   output logic                 o_busy
);

   localparam int             BCW       = $clog2(DATAWIDTH) + 1;
   localparam logic [15:0]    BAUD_FULL = 16'(CLKS_PER_BAUD - 1);
   localparam logic [15:0]    BAUD_HALF = 16'(CLKS_PER_BAUD / 2 - 1);
   localparam logic [BCW-1:0] LAST_BIT  = BCW'(DATAWIDTH - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
`ifdef UART_RX_BREAK_DETECT_EN
      ST_STOP,
      ST_BREAK
`else
      ST_STOP
`endif
   } state_t;

   state_t               r_state;
   state_t               w_nextState;
   logic                 r_rxMeta;
   logic                 r_rxS;
   logic [15:0]          r_baudCnt;
   logic [15:0]          w_baudCntNext;
   logic [BCW-1:0]       r_bitCnt;
   logic [BCW-1:0]       w_bitCntNext;
   logic [DATAWIDTH-1:0] r_shreg;
   logic [DATAWIDTH-1:0] w_shregNext;
   logic                 r_perr;
   logic                 w_perrNext;
   logic                 r_ferr;
   logic                 w_ferrNext;
   logic                 w_parity;
   logic                 w_sample;
   logic                 w_done;
`ifdef UART_RX_BREAK_DETECT_EN
   logic                 r_parBit;
   logic                 w_parBitNext;
   logic                 w_isBreak;
`endif

   // A sample event happens whenever the bit-period counter reaches zero
   // while a frame is being received. Every per-bit decision in the
   // next-state logic hangs off this strobe.
   assign w_sample = (r_state != ST_IDLE) && (r_baudCnt == 16'd0);
   assign o_busy   = (r_state != ST_IDLE);

   // The two-flop synchroniser resets to the idle (high) level, so a reset
   // never looks like the leading edge of a start bit.
   always_ff @(posedge clk) begin
      if (i_reset) begin
         r_rxMeta <= 1'b1;
         r_rxS    <= 1'b1;
      end else begin
         r_rxMeta <= i_rx_data;
         r_rxS    <= r_rxMeta;
      end
   end

   // State register of the receive FSM. Reset aborts any frame in flight.
   always_ff @(posedge clk) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state and datapath-next logic. Between samples, the baud counter
   // simply counts down. On each sample, the current state decides what to
   // do with rx_s and reloads the counter for the next bit centre. The
   // start bit is only half a period long, so the counter lands on the
   // middle of every following bit. The final stop sample returns the FSM
   // to IDLE straight away, so a back-to-back start bit is caught from
   // mid-stop onward.
   always_comb begin
      w_nextState   = r_state;
      w_baudCntNext = r_baudCnt;
      w_bitCntNext  = r_bitCnt;
      w_shregNext   = r_shreg;
      w_perrNext    = r_perr;
      w_ferrNext    = r_ferr;
      w_parity      = 1'b0;
      w_done        = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      w_parBitNext  = r_parBit;
      w_isBreak     = 1'b0;
`endif

      if ((r_state != ST_IDLE) && !w_sample) begin
         w_baudCntNext = r_baudCnt - 16'd1;
      end

      unique case (r_state)
         ST_IDLE: begin
            if (!r_rxS) begin
               w_nextState   = ST_START;
               w_baudCntNext = BAUD_HALF;
               w_perrNext    = 1'b0;
               w_ferrNext    = 1'b0;
            end
         end
         ST_START: begin
            if (w_sample) begin
               if (r_rxS) begin
                  w_nextState = ST_IDLE;
               end else begin
                  w_nextState   = ST_DATA;
                  w_baudCntNext = BAUD_FULL;
                  w_bitCntNext  = '0;
               end
            end
         end
         ST_DATA: begin
            if (w_sample) begin
               w_shregNext   = {r_rxS, r_shreg[DATAWIDTH-1:1]};
               w_bitCntNext  = r_bitCnt + 1'b1;
               w_baudCntNext = BAUD_FULL;
               if (r_bitCnt == LAST_BIT) begin
                  w_nextState  = (PARITY != 0) ? ST_PARITY : ST_STOP;
                  w_bitCntNext = '0;
               end
            end
         end
         ST_PARITY: begin
            if (w_sample) begin
               w_parity      = (^r_shreg) ^ r_rxS;
               w_perrNext    = (PARITY == 1) ? ~w_parity : w_parity;
               w_nextState   = ST_STOP;
               w_baudCntNext = BAUD_FULL;
`ifdef UART_RX_BREAK_DETECT_EN
               w_parBitNext  = r_rxS;
`endif
            end
         end
         ST_STOP: begin
            if (w_sample) begin
               w_ferrNext = r_ferr | ~r_rxS;
               if ((STOP_BITS == 2) && (r_bitCnt == '0)) begin
                  w_bitCntNext  = {{(BCW-1){1'b0}}, 1'b1};
                  w_baudCntNext = BAUD_FULL;
               end else begin
                  w_done      = 1'b1;
                  w_nextState = ST_IDLE;
`ifdef UART_RX_BREAK_DETECT_EN
                  if ((r_shreg == '0) && w_ferrNext && ((PARITY == 0) || !r_parBit)) begin
                     w_isBreak   = 1'b1;
                     w_nextState = ST_BREAK;
                  end
`endif
               end
            end
         end
`ifdef UART_RX_BREAK_DETECT_EN
         ST_BREAK: begin
            if (r_rxS) begin
               w_nextState = ST_IDLE;
            end
         end
`endif
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   // Datapath registers and the delivered word. The outputs load only on
   // frame completion, so o_data and the error flags hold until the next
   // o_wr. The frame error includes the stop sample taken this cycle.
   always_ff @(posedge clk) begin
      if (i_reset) begin
         r_baudCnt    <= '0;
         r_bitCnt     <= '0;
         r_shreg      <= '0;
         r_perr       <= 1'b0;
         r_ferr       <= 1'b0;
         o_wr         <= 1'b0;
         o_data       <= '0;
         o_parity_err <= 1'b0;
         o_frame_err  <= 1'b0;
      end else begin
         r_baudCnt <= w_baudCntNext;
         r_bitCnt  <= w_bitCntNext;
         r_shreg   <= w_shregNext;
         r_perr    <= w_perrNext;
         r_ferr    <= w_ferrNext;
         o_wr      <= w_done;
         if (w_done) begin
            o_data       <= r_shreg;
            o_parity_err <= r_perr;
            o_frame_err  <= w_ferrNext;
         end
      end
   end

`ifdef UART_RX_BREAK_DETECT_EN
   // Break bookkeeping: remember the sampled parity bit, since a break
   // needs it low too. o_break is published alongside the other flags.
   always_ff @(posedge clk) begin
      if (i_reset) begin
         r_parBit <= 1'b0;
         o_break  <= 1'b0;
      end else begin
         r_parBit <= w_parBitNext;
         if (w_done) begin
            o_break <= w_isBreak;
         end
      end
   end
`else
   // Without break detection, the break flag is permanently low.
   assign o_break = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// ---------------------------------------------------------------------------
// TbUartRxCore (module tb_uart_rx_core)
//
// Self-checking bench for uart_rx_core. It uses three receivers, each with
// its own serial line:
//   A: 8N1
//   B: 8 data bits, even parity, 1 stop bit
//   C: 8 data bits, odd parity, 2 stop bits
//
// Frames are built bit by bit from a word plus error-injection knobs.
// Their expected results come from frame-level arithmetic and are queued
// per receiver. A negedge monitor pops the queue on every o_wr.
// Honours UART_RX_BREAK_DETECT_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_uart_rx_core;

   localparam int C  = 16;
   localparam int DW = 8;
`ifdef UART_RX_BREAK_DETECT_EN
   localparam bit BRK_EN = 1'b1;
`else
   localparam bit BRK_EN = 1'b0;
`endif

   typedef struct {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
      logic       brk;
   } frame_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic rxA   = 1'b1;
   logic rxB   = 1'b1;
   logic rxC   = 1'b1;

   logic         wrA, perrA, ferrA, brkA, busyA;
   logic         wrB, perrB, ferrB, brkB, busyB;
   logic         wrC, perrC, ferrC, brkC, busyC;
   logic [DW-1:0] dataA, dataB, dataC;

   frame_t expA[$];
   frame_t expB[$];
   frame_t expC[$];

   int errors    = 0;
   int checks    = 0;
   bit holdMode  = 1'b0;
   int holdCount = 0;

   always #5 clk = ~clk;

   uart_rx_core #(.CLKS_PER_BAUD(C), .DATAWIDTH(DW), .PARITY(0), .STOP_BITS(1)) dutA (
      .clk(clk), .i_reset(reset), .i_rx_data(rxA), .o_wr(wrA), .o_data(dataA),
      .o_parity_err(perrA), .o_frame_err(ferrA), .o_break(brkA), .o_busy(busyA));

   uart_rx_core #(.CLKS_PER_BAUD(C), .DATAWIDTH(DW), .PARITY(2), .STOP_BITS(1)) dutB (
      .clk(clk), .i_reset(reset), .i_rx_data(rxB), .o_wr(wrB), .o_data(dataB),
      .o_parity_err(perrB), .o_frame_err(ferrB), .o_break(brkB), .o_busy(busyB));

   uart_rx_core #(.CLKS_PER_BAUD(C), .DATAWIDTH(DW), .PARITY(1), .STOP_BITS(2)) dutC (
      .clk(clk), .i_reset(reset), .i_rx_data(rxC), .o_wr(wrC), .o_data(dataC),
      .o_parity_err(perrC), .o_frame_err(ferrC), .o_break(brkC), .o_busy(busyC));

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   function automatic int parOf(input int sel);
      case (sel)
         0:       return 0;
         1:       return 2;
         default: return 1;
      endcase
   endfunction

   function automatic int stopsOf(input int sel);
      return (sel == 2) ? 2 : 1;
   endfunction

   // Drive one bit period on the selected line, ending just after a rising edge.
   task automatic holdBit(input int sel, input logic v);
      case (sel)
         0:       rxA = v;
         1:       rxB = v;
         default: rxC = v;
      endcase
      repeat (C) @(posedge clk);
      #1;
   endtask

   // Build and send one frame. The expected word and flags come straight
   // from the word, the parity rule and the injected faults.
   task automatic applyStimulus(input int sel, input logic [7:0] data, input bit parBad,
                                input bit s1Low, input bit s2Low, input int gapBits);
      int     par;
      int     stops;
      logic   pbit;
      frame_t f;
      par   = parOf(sel);
      stops = stopsOf(sel);
      if (par == 2) pbit = ($countones(data) % 2) != 0;
      else          pbit = ($countones(data) % 2) == 0;
      if (parBad) pbit = ~pbit;
      f.data = data;
      f.perr = (par != 0) && parBad;
      f.ferr = s1Low || ((stops == 2) && s2Low);
      f.brk  = BRK_EN && (data == 8'h00) && f.ferr && ((par == 0) || (pbit == 1'b0));
      case (sel)
         0:       expA.push_back(f);
         1:       expB.push_back(f);
         default: expC.push_back(f);
      endcase
      holdBit(sel, 1'b0);
      for (int i = 0; i < DW; i++) holdBit(sel, data[i]);
      if (par != 0) holdBit(sel, pbit);
      holdBit(sel, ~s1Low);
      if (stops == 2) holdBit(sel, ~s2Low);
      repeat (gapBits) holdBit(sel, 1'b1);
   endtask

   task automatic popCheck(input int sel, input logic [7:0] d, input logic pe, input logic fe, input logic bk);
      frame_t f;
      int     n;
      n = (sel == 0) ? expA.size() : (sel == 1) ? expB.size() : expC.size();
      checkOutput($sformatf("dut%0d_wr_expected", sel), 32'(n != 0), 32'd1);
      if (n != 0) begin
         case (sel)
            0:       f = expA.pop_front();
            1:       f = expB.pop_front();
            default: f = expC.pop_front();
         endcase
         checkOutput($sformatf("dut%0d_data", sel), 32'(d), 32'(f.data));
         checkOutput($sformatf("dut%0d_perr", sel), 32'(pe), 32'(f.perr));
         checkOutput($sformatf("dut%0d_ferr", sel), 32'(fe), 32'(f.ferr));
         checkOutput($sformatf("dut%0d_brk", sel), 32'(bk), 32'(f.brk));
      end
   endtask

   task automatic waitDrain(input string tag);
      int budget;
      budget = 40 * C;
      while ((expA.size() + expB.size() + expC.size()) != 0 && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      #1;
      checkOutput(tag, 32'(expA.size() + expB.size() + expC.size()), 32'd0);
   endtask

   task automatic randomFrames(input int sel, input int count);
      logic [7:0] d;
      bit         pb, s1, s2;
      int         gap;
      for (int i = 0; i < count; i++) begin
         d   = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 7) == 0) d = 8'h00;
         pb  = ($urandom_range(0, 3) == 0);
         s1  = ($urandom_range(0, 4) == 0);
         s2  = ($urandom_range(0, 4) == 0);
         gap = $urandom_range(0, 2);
         if (s1 || s2) gap = gap + 1;
         applyStimulus(sel, d, pb, s1, s2, gap);
      end
   endtask

   // Monitors: every o_wr pulse is matched against the expected queue of
   // its receiver. Held-low frames are only tallied and sanity-checked.
   always @(negedge clk) begin
      if (wrA === 1'b1) begin
         if (holdMode) begin
            holdCount++;
            checkOutput("hold_data", 32'(dataA), 32'd0);
            checkOutput("hold_ferr", 32'(ferrA), 32'd1);
            checkOutput("hold_brk", 32'(brkA), 32'(BRK_EN));
         end else begin
            popCheck(0, dataA, perrA, ferrA, brkA);
         end
      end
      if (wrB === 1'b1) popCheck(1, dataB, perrB, ferrB, brkB);
      if (wrC === 1'b1) popCheck(2, dataC, perrC, ferrC, brkC);
   end

   // Watchdog so the run always ends.
   initial begin
      repeat (60000) @(posedge clk);
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0] d;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_A", {wrA, dataA, perrA, ferrA, brkA, busyA}, 32'd0);
      checkOutput("rst_B", {wrB, dataB, perrB, ferrB, brkB, busyB}, 32'd0);
      checkOutput("rst_C", {wrC, dataC, perrC, ferrC, brkC, busyC}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (2) holdBit(0, 1'b1);

      $display("[TB] 8N1 back-to-back frames");
      applyStimulus(0, 8'hA5, 1'b0, 1'b0, 1'b0, 0);
      applyStimulus(0, 8'h3C, 1'b0, 1'b0, 1'b0, 2);
      waitDrain("drain_b2b");

      $display("[TB] glitch on idle line");
      rxA = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rxA = 1'b1;
      @(negedge clk);
      checkOutput("glitch_busy_high", 32'(busyA), 32'd1);
      repeat (2 * C) @(posedge clk);
      #1;
      checkOutput("glitch_busy_low", 32'(busyA), 32'd0);

      $display("[TB] reset during data bit 3");
      d = 8'hA5;
      holdBit(0, 1'b0);
      for (int i = 0; i < 3; i++) holdBit(0, d[i]);
      rxA = d[3];
      repeat (C / 2) @(posedge clk);
      #1;
      reset = 1'b1;
      rxA   = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      checkOutput("midreset_outputs", {wrA, dataA, perrA, ferrA, brkA, busyA}, 32'd0);
      repeat (2) holdBit(0, 1'b1);
      applyStimulus(0, 8'h81, 1'b0, 1'b0, 1'b0, 1);
      waitDrain("drain_after_reset");

      $display("[TB] random 8N1 frames");
      randomFrames(0, 20);
      holdBit(0, 1'b1);
      waitDrain("drain_rand_A");

      $display("[TB] line held low");
      holdMode  = 1'b1;
      holdCount = 0;
      rxA       = 1'b0;
      repeat (40 * C) @(posedge clk);
      #1;
      if (BRK_EN) begin
         rxA = 1'b1;
         repeat (3 * C) @(posedge clk);
         #1;
         checkOutput("break_count", 32'(holdCount), 32'd1);
         checkOutput("break_idle", 32'(busyA), 32'd0);
      end else begin
         reset = 1'b1;
         rxA   = 1'b1;
         repeat (2) @(posedge clk);
         #1;
         reset = 1'b0;
         checkOutput("hold_repeats", 32'(holdCount >= 3), 32'd1);
      end
      holdMode = 1'b0;

      $display("[TB] even parity frames");
      repeat (2) holdBit(1, 1'b1);
      applyStimulus(1, 8'h07, 1'b1, 1'b0, 1'b0, 1);
      applyStimulus(1, 8'h07, 1'b0, 1'b0, 1'b0, 1);
      randomFrames(1, 20);
      holdBit(1, 1'b1);
      waitDrain("drain_B");

      $display("[TB] odd parity, two stop bits");
      repeat (2) holdBit(2, 1'b1);
      applyStimulus(2, 8'h55, 1'b0, 1'b0, 1'b1, 1);
      applyStimulus(2, 8'h55, 1'b0, 1'b0, 1'b0, 0);
      randomFrames(2, 20);
      holdBit(2, 1'b1);
      waitDrain("drain_C");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Parametrised UART receiver, successor to the fixed 8N1/9600-baud receiver. It adds:
- configurable baud divisor, data width, parity and stop-bit count;
- a synchronous reset;
- start-bit validation;
- parity and framing error reporting.

It sits between the external RX pin and the SoC's UART register/FIFO layer, delivering one word per `o_wr` pulse.

## Interface
- `CLKS_PER_BAUD`, default 10416: clk cycles per bit; legal range 4..65535.
- `DATAWIDTH`, default 8: data bits per frame; legal range 5..8.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: 1 or 2.
- `clk` input, 1 bit: single system clock, rising edge.
- `i_reset` input, 1 bit: synchronous, active-high reset.
- `i_rx_data` input, 1 bit: asynchronous serial line, idle high.
- `o_wr` output, 1 bit: one-cycle pulse; word and status are valid.
- `o_data` output, DATAWIDTH bits: received word, LSB = first bit on the wire.
- `o_parity_err` output, 1 bit: parity mismatch; valid with `o_wr`.
- `o_frame_err` output, 1 bit: a stop bit sampled low; valid with `o_wr`.
- `o_break` output, 1 bit: break detected; valid with `o_wr`. Constant 0 unless `UART_RX_BREAK_DETECT_EN` is defined.
- `o_busy` output, 1 bit: high whenever the state is not IDLE.

## Operation
- **Input synchroniser:** 2-flop synchroniser on `i_rx_data`. Both flops reset and initialise to 1. All decisions use the second flop, `rx_s`.
- **States:** IDLE, START, DATA, PARITY, STOP, BREAK.
  - BREAK exists only with the macro.
  - The state register is 3 bits.
- **Counters:**
  - Down-counter `baud_cnt`, 16 bits.
  - Bit index `bit_cnt`, width $clog2(DATAWIDTH)+1.
  - A sample event is `baud_cnt == 0` in any non-IDLE state.
- **IDLE:** when `rx_s` is 0, go to START with `baud_cnt = CLKS_PER_BAUD/2 - 1` (integer division).
- **START sample:**
  - `rx_s == 1`: false start; return to IDLE with no output.
  - Otherwise go to DATA with `baud_cnt = CLKS_PER_BAUD - 1` and `bit_cnt = 0`.
- **DATA sample:**
  - Shift: `shreg <= {rx_s, shreg[DATAWIDTH-1:1]}`, then increment `bit_cnt`.
  - After sample DATAWIDTH-1, go to PARITY if `PARITY != 0`, else to STOP.
  - Reload `baud_cnt = CLKS_PER_BAUD - 1` at every sample.
- **PARITY sample:** let `p` be the XOR of the data bits and `rx_s`.
  - Error when `p != 1` for odd parity.
  - Error when `p != 0` for even parity.
  - The result is latched in `perr_q`.
- **STOP sample:**
  - `rx_s == 0` sets `ferr_q`.
  - With `STOP_BITS == 2`, the first stop sample reloads `baud_cnt` and stays in STOP; the second sample completes the frame.
  - Both stop samples contribute to `ferr_q`.
- **Frame completion:**
  - Registered outputs take: `o_data <= shreg`, `o_parity_err <= perr_q`, `o_frame_err <= ferr_q`, `o_wr <= 1`.
  - Next state is IDLE, so the next start bit can be detected from mid-stop onward.
- `o_data` and the error flags hold their values until the next `o_wr`.
- Error flags are cleared on entry to START.
- **Reset:** `i_reset` high at any clock edge forces all of the following, aborting any frame in progress with no `o_wr`:
  - state = IDLE;
  - `baud_cnt = 0`, `bit_cnt = 0`;
  - `shreg = 0`, `o_data = 0`;
  - `o_wr = 0`, `o_parity_err = 0`, `o_frame_err = 0`, `o_break = 0`;
  - synchroniser flops = 1.

## Timing
- Pin-to-IDLE-detect latency is 2 cycles through the synchroniser.
- **Sample points**, relative to the cycle START is entered (cycle 0):
  - START sample at cycle `CLKS_PER_BAUD/2 - 1`.
  - Data bit k sampled `(k+1)*CLKS_PER_BAUD` cycles after the START sample.
- `o_wr` is high exactly one cycle: the cycle after the final stop sample.
- Back-to-back frames with no idle gap must be received without loss.
- Reset overrides all other events in the same cycle.
- A `rx_s` change during a non-sample cycle has no effect.

## Configuration
- **`UART_RX_BREAK_DETECT_EN` defined:**
  - Break is declared when `shreg == 0`, `ferr_q == 1`, and the parity bit (if present) also sampled 0.
  - On a break, `o_wr` pulses with `o_break = 1` and `o_frame_err = 1`, and the state goes to BREAK instead of IDLE.
  - BREAK waits until `rx_s == 1` for one sample-free cycle, then goes to IDLE.
  - A held-low line therefore yields exactly one `o_wr`.
- **Macro undefined:**
  - `o_break` is tied to 0 and the BREAK state is absent.
  - A held-low line produces repeated frames, each with `o_frame_err = 1` and `o_data = 0`.

## Test plan
Unless stated, benches use `CLKS_PER_BAUD = 16` and `DATAWIDTH = 8`.
1. 8N1, send 0xA5 then 0x3C back-to-back -> two `o_wr` pulses; `o_data` = 0xA5 then 0x3C; all error flags 0.
2. `PARITY = 2`, send 0x07 with parity bit 0 (wrong) -> `o_wr` with `o_data = 0x07` and `o_parity_err = 1`. Resend with parity 1 -> `o_parity_err = 0`.
3. Low glitch of 4 cycles on an idle line -> state returns to IDLE; no `o_wr`.
4. `STOP_BITS = 2`, second stop bit driven low for the send of 0x55 -> `o_wr` with `o_data = 0x55` and `o_frame_err = 1`.
5. Assert `i_reset` for 1 cycle mid-way through data bit 3 -> no `o_wr`; outputs 0; a following 0x81 frame is received correctly.
6. Line held low for 40 bit times -> with the macro, exactly one `o_wr` with `o_break = 1`; without it, repeated `o_wr` with `o_frame_err = 1` and `o_data = 0x00`.
